// File: rtl/i2c_temp_read_sequencer.sv
// rtl/i2c_temp_read_sequencer.sv - bit-level I2C master sequencer for one TMP101 two-byte temperature read
module i2c_temp_read_sequencer #(
  parameter logic [6:0] SlaveAddress     = 7'b1001001,
  parameter int         ClocksPerQuarter = 500
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        Go,
  input  logic        SDAIn,
  output logic        SDADriveLow,
  output logic        SCL,
  output logic        Busy,
  output logic        Done,
  output logic        AckError,
  output logic [15:0] Temperature
);

  localparam int            CW       = $clog2(ClocksPerQuarter);
  localparam logic [CW-1:0] CntLast  = CW'(ClocksPerQuarter - 1);
  localparam logic [CW-1:0] CntPre   = CW'(ClocksPerQuarter - 2);
  localparam logic [7:0]    AddrByte = {SlaveAddress, 1'b1};

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, READ_MSB, M_ACK, READ_LSB, M_NACK, STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    quarter_q, quarter_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    msb_q, msb_d;
  logic          ack_sample_q, ack_sample_d;
  logic          scl_q, scl_d;
  logic          sda_low_q, sda_low_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_error_q, ack_error_d;
  logic [15:0]   temperature_q, temperature_d;
  logic          tick;

  // Bus levels {SCL, SDADriveLow} for a given state, quarter and bit position.
  function automatic logic [1:0] bus_levels(state_t st, logic [1:0] qtr, logic [2:0] bit_idx);
    logic [1:0] lv;
    case (st)
      START:    lv = {1'b1, qtr[1]};
      ADDR:     lv = {qtr[1], ~AddrByte[3'd7 - bit_idx]};
      ADDR_ACK, READ_MSB, READ_LSB, M_NACK: lv = {qtr[1], 1'b0};
      M_ACK:    lv = {qtr[1], 1'b1};
      STOP:     lv = (qtr == 2'd0) ? 2'b01 : (qtr == 2'd1) ? 2'b11 : 2'b10;
      default:  lv = 2'b10;
    endcase
    return lv;
  endfunction

  // Next-state logic: quarter timing, slot sequencing, SDA sampling and result capture.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    quarter_d     = quarter_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    msb_d         = msb_q;
    ack_sample_d  = ack_sample_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    ack_error_d   = ack_error_q;
    temperature_d = temperature_q;
    tick          = (cnt_q == CntLast);

    if (state_q == IDLE) begin
      cnt_d     = '0;
      quarter_d = 2'd0;
      // A Go landing in the Done cycle is dropped so each Go maps to one transaction.
      if (Go && !done_q) begin
        state_d     = START;
        busy_d      = 1'b1;
        ack_error_d = 1'b0;
        bit_d       = 3'd0;
      end
    end else if (state_q == STOP && quarter_q == 2'd3 && cnt_q == CntPre) begin
      // Done overlaps the final STOP cycle; the bus levels are identical to IDLE there.
      state_d   = IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      cnt_d     = '0;
      quarter_d = 2'd0;
      if (!ack_error_q) temperature_d = {msb_q, shift_q};
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick && quarter_q == 2'd2) begin
        if (state_q == READ_MSB || state_q == READ_LSB) shift_d = {shift_q[6:0], SDAIn};
        if (state_q == ADDR_ACK) ack_sample_d = SDAIn;
      end
      if (tick) begin
        quarter_d = quarter_q + 2'd1;
        if (quarter_q == 2'd3) begin
          case (state_q)
            START: begin
              state_d = ADDR;
              bit_d   = 3'd0;
            end
            ADDR: begin
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = ADDR_ACK;
            end
            ADDR_ACK: begin
              bit_d = 3'd0;
              if (ack_sample_q) begin
                state_d     = STOP;
                ack_error_d = 1'b1;
              end else begin
                state_d = READ_MSB;
              end
            end
            READ_MSB: begin
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                state_d = M_ACK;
                msb_d   = shift_q;
              end
            end
            M_ACK: begin
              state_d = READ_LSB;
              bit_d   = 3'd0;
            end
            READ_LSB: begin
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = M_NACK;
            end
            M_NACK:  state_d = STOP;
            default: state_d = state_q;
          endcase
        end
      end
    end

    {scl_d, sda_low_d} = bus_levels(state_d, quarter_d, bit_d);
  end

  // State and registered outputs; reset releases the bus immediately with no STOP.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      quarter_q     <= 2'd0;
      bit_q         <= 3'd0;
      shift_q       <= 8'h00;
      msb_q         <= 8'h00;
      ack_sample_q  <= 1'b0;
      scl_q         <= 1'b1;
      sda_low_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ack_error_q   <= 1'b0;
      temperature_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      quarter_q     <= quarter_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      msb_q         <= msb_d;
      ack_sample_q  <= ack_sample_d;
      scl_q         <= scl_d;
      sda_low_q     <= sda_low_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ack_error_q   <= ack_error_d;
      temperature_q <= temperature_d;
    end
  end

  assign SCL         = scl_q;
  assign SDADriveLow = sda_low_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign AckError    = ack_error_q;
  assign Temperature = temperature_q;

endmodule

// File: tb/tb_i2c_temp_read_sequencer.sv
// tb/tb_i2c_temp_read_sequencer.sv - scoreboard bench with TMP101 slave model for the read sequencer
module tb_i2c_temp_read_sequencer;
  localparam int Q = 2;

  logic        clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Go = 1'b0;
  logic        SDAIn;
  logic        SDADriveLow, SCL, Busy, Done, AckError;
  logic [15:0] Temperature;

  i2c_temp_read_sequencer #(.SlaveAddress(7'b1001001), .ClocksPerQuarter(Q)) dut (
    .clock(clock), .Reset(Reset), .Go(Go), .SDAIn(SDAIn),
    .SDADriveLow(SDADriveLow), .SCL(SCL), .Busy(Busy), .Done(Done),
    .AckError(AckError), .Temperature(Temperature)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Open-drain wired-AND of master and slave.
  logic slave_low = 1'b0;
  assign SDAIn = !(SDADriveLow || slave_low);

  logic       cfg_ack = 1'b1;
  logic [7:0] cfg_msb = 8'h00;
  logic [7:0] cfg_lsb = 8'h00;
  logic [7:0] addr_seen = 8'h00;
  logic       mack_seen = 1'b1;
  logic       mnack_seen = 1'b0;
  int         fall_cnt = 99;
  logic       prev_scl = 1'b1;
  logic       prev_line = 1'b1;

  typedef struct {
    logic [15:0] temp;
    logic        ack_err;
    int          done_cyc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  logic [15:0] model_temp = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Slave: finds START, counts SCL falls into slot numbers, drives ACK/data, records master bits.
  always @(negedge clock) begin : slave_model
    logic line;
    int   slot;
    line = !(SDADriveLow || slave_low);
    if (Reset) begin
      slave_low = 1'b0;
      fall_cnt  = 99;
    end else if (prev_scl && SCL && prev_line && !line) begin
      fall_cnt  = 0;
      slave_low = 1'b0;
      addr_seen = 8'h00;
    end else if (prev_scl && !SCL) begin
      slave_low = 1'b0;
      if (fall_cnt == 8) slave_low = cfg_ack;
      else if (cfg_ack && fall_cnt >= 9 && fall_cnt <= 16) slave_low = !cfg_msb[16 - fall_cnt];
      else if (cfg_ack && fall_cnt >= 18 && fall_cnt <= 25) slave_low = !cfg_lsb[25 - fall_cnt];
      fall_cnt++;
    end else if (!prev_scl && SCL) begin
      slot = fall_cnt - 1;
      if (slot >= 0 && slot <= 7) addr_seen = {addr_seen[6:0], line};
      if (slot == 17) mack_seen = line;
      if (slot == 26) mnack_seen = line;
    end
    prev_scl  = SCL;
    prev_line = !(SDADriveLow || slave_low);
  end

  // Monitor: every Done pops one expectation and checks the result and the bus bits seen.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!Reset && Done) begin
      check("done_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("temperature", Temperature, e.temp);
        check("ack_error", AckError, e.ack_err);
        check("done_latency", cyc, e.done_cyc);
        check("busy_at_done", Busy, 0);
        check("addr_byte", addr_seen, 8'h93);
        if (!e.ack_err) begin
          check("master_ack", mack_seen, 0);
          check("master_nack", mnack_seen, 1);
        end
      end
    end
  end

  task automatic pulse_go(input bit push, input bit ack, input logic [7:0] msb, input logic [7:0] lsb,
                          output int go_cyc);
    exp_t e;
    @(posedge clock);
    #1;
    cfg_ack = ack;
    cfg_msb = msb;
    cfg_lsb = lsb;
    Go      = 1'b1;
    go_cyc  = cyc;
    if (push) begin
      if (ack) model_temp = {msb, lsb};
      e.temp     = model_temp;
      e.ack_err  = !ack;
      e.done_cyc = go_cyc + (ack ? 116 : 44) * Q;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    Go = 1'b0;
    if (push) check("busy_after_go", Busy, 1);
  endtask

  task automatic wait_cycle(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic raw_go_at(input int n);
    wait_cycle(n);
    Go = 1'b1;
    @(posedge clock);
    #1;
    Go = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clock);
    check("drain_pending", exp_q.size(), 0);
    repeat (4) @(posedge clock);
  endtask

  initial begin : stimulus
    int c;
    Reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    Reset = 1'b0;
    @(negedge clock);
    check("rst_scl", SCL, 1);
    check("rst_sda", SDADriveLow, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_ackerr", AckError, 0);
    check("rst_temp", Temperature, 16'h0000);

    pulse_go(1, 1, 8'h19, 8'h00, c);
    drain();

    pulse_go(1, 0, 8'hAA, 8'hBB, c);
    drain();

    pulse_go(1, 1, 8'h12, 8'h34, c);
    raw_go_at(c + 10);
    raw_go_at(c + 100);
    raw_go_at(c + 116 * Q);
    drain();
    repeat (300) @(posedge clock);
    check("extra_go_no_done", exp_q.size(), 0);
    check("extra_go_busy", Busy, 0);

    pulse_go(0, 1, 8'hAA, 8'h55, c);
    wait_cycle(c + 90);
    Reset = 1'b1;
    @(posedge clock);
    #1;
    Reset = 1'b0;
    check("abort_scl", SCL, 1);
    check("abort_sda", SDADriveLow, 0);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    model_temp = 16'h0000;
    repeat (300) @(posedge clock);
    #1;
    check("abort_temp", Temperature, 16'h0000);
    check("abort_scl_idle", SCL, 1);
    pulse_go(1, 1, 8'h55, 8'hAA, c);
    drain();

    pulse_go(1, 1, 8'hE7, 8'h00, c);
    drain();
    pulse_go(1, 1, 8'h7F, 8'hF0, c);
    drain();
    @(negedge clock);
    check("final_temp", Temperature, 16'h7FF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
